mac_seq_controller: RTL and testbench
=====================================

Name: mac_seq_controller

Overview:
- Parametrised successor to the fixed 6-state load/multiply/sum controller that drives the CA2 datapath.
- Sequences NUM_CH channel loads, a multi-cycle multiply window and a single-cycle sum, then repeats for a runtime-programmed iteration count.
- Iteration 0 takes new external operands; later iterations take the fed-back result.
- Adds abort, a done/ack handshake, busy and an iteration index. Sits between the top-level start/done interface and the register/multiplier/adder datapath.

Parameters:
- NUM_CH, 2, operand channels loaded per iteration (>=1).
- CH_W, 1, width of ch_sel; must satisfy 2**CH_W >= NUM_CH.
- MUL_LAT, 1, cycles mul_en is held per iteration (>=1).
- ITER_W, 4, width of iter_num and iter_idx.
- AUTO_ACK, 0, 1 means DONE lasts exactly one cycle and done_ack is ignored.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin operation; sampled only in IDLE
- iter_num  input  ITER_W  iteration count, latched on accepted start
- abort  input  1  cancel operation, return to IDLE
- done_ack  input  1  releases DONE (when AUTO_ACK=0)
- input_en  output  1  datapath may capture external inputs (IDLE)
- load_in  output  1  load operand register ch_sel
- ch_sel  output  CH_W  channel being loaded
- sel_old_or_new  output  1  1 = new external operand, 0 = fed-back result
- mul_en  output  1  multiplier enable
- sum_en  output  1  accumulator/adder enable
- done  output  1  result valid
- busy  output  1  high in every state except IDLE
- iter_idx  output  ITER_W  current iteration, 0-based

Behaviour:
- All outputs are Moore outputs decoded from registered state and counters. There is no combinational input-to-output path.
- Reset (rst=0, async): state=IDLE, ch/mul/iter counters=0, iter_total=0.
  - Output values during reset: input_en=1; ch_sel=0; iter_idx=0; all other outputs 0.
- IDLE: input_en=1.
  - start=1: latch iter_total=iter_num (iter_num=0 is treated as 1), clear counters, go to LOAD.
- LOAD: load_in=1, ch_sel=ch count, sel_old_or_new=(iter_idx==0).
  - ch increments each cycle.
  - At ch==NUM_CH-1: go to MUL, clear ch.
- MUL: mul_en=1, mul counter increments.
  - At count==MUL_LAT-1: go to SUM.
- SUM: sum_en=1 for one cycle.
  - If iter_idx==iter_total-1: go to DONE.
  - Otherwise iter_idx++ and go to LOAD.
- DONE: done=1.
  - AUTO_ACK=0: hold until done_ack=1, then go to IDLE.
  - AUTO_ACK=1: go to IDLE after one cycle.
- Timing: each iteration takes NUM_CH+MUL_LAT+1 cycles. With start sampled at edge E0, load_in is high in the cycle after E0, and done first rises N*(NUM_CH+MUL_LAT+1) cycles after E0.
- Priority:
  - abort=1 in LOAD/MUL/SUM/DONE wins over every other transition: next state IDLE, counters cleared, done never asserted.
  - abort in IDLE has no effect, and start is ignored that cycle.
- start outside IDLE is ignored. iter_num changes after acceptance are ignored.
- done_ack outside DONE is ignored. done_ack together with start in DONE returns to IDLE; start is not accepted until IDLE.
- Reset mid-operation: immediate return to IDLE, outputs to reset values.
- Exactly one of input_en/load_in/mul_en/sum_en/done is high at any time. busy = !input_en.
- Counters never exceed their bounds; iter_total=2**ITER_W-1 is supported without wrap.

Decomposition:
- Shared package mac_ctrl_pkg:
  - 3-bit state encoding localparams: IDLE=0, LOAD=1, MUL=2, SUM=3, DONE=4.
  - Shared with the top-level status decoder.
- One natural sub-module, ctrl_counter: parametrised-width up-counter with async active-low reset, sync clear, enable and a terminal-count output.
  - Instantiated three times: ch, mul, iter.

Test Plan:
- Reset check (NUM_CH=2, MUL_LAT=1, ITER_W=4): assert rst=0 mid-stream -> outputs immediately input_en=1, all others 0, ch_sel=0, iter_idx=0.
- Single iteration: start=1, iter_num=1 ->
  - load_in in cycles 1-2 with ch_sel 0,1 and sel_old_or_new=1;
  - mul_en in cycle 3, sum_en in cycle 4;
  - done from cycle 5 until done_ack; busy falls the cycle after ack.
- Three iterations: iter_num=3 ->
  - sel_old_or_new=1 only in iteration 0;
  - iter_idx steps 0,1,2;
  - done rises 12 cycles after the start edge.
- iter_num=0 and MUL_LAT=3 -> behaves as 1 iteration; mul_en held 3 cycles; done after 6 cycles.
- Abort during MUL of iteration 1 (iter_num=3) -> next cycle IDLE; done stays 0; a new start is accepted and runs normally.
- AUTO_ACK=1, start held high continuously -> done pulses for exactly 1 cycle, then 1 IDLE cycle, then a new run starts.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC sequence controller: state encoding, the
// one-hot datapath strobe bundle and the per-state strobe decode.
package mac_ctrl_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] MUL  = 3'd2;
    localparam logic [2:0] SUM  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = IDLE,
        ST_LOAD = LOAD,
        ST_MUL  = MUL,
        ST_SUM  = SUM,
        ST_DONE = DONE
    } state_e;

    typedef struct packed {
        logic input_en;
        logic load_in;
        logic mul_en;
        logic sum_en;
        logic done;
    } ctrl_flags_t;

    // Exactly one strobe per state; unknown encodings fall back to the IDLE strobe.
    function automatic ctrl_flags_t state_flags(input state_e s);
        ctrl_flags_t f;
        f = '0;
        case (s)
            ST_IDLE: f.input_en = 1'b1;
            ST_LOAD: f.load_in  = 1'b1;
            ST_MUL:  f.mul_en   = 1'b1;
            ST_SUM:  f.sum_en   = 1'b1;
            ST_DONE: f.done     = 1'b1;
            default: f.input_en = 1'b1;
        endcase
        return f;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ctrl_counter.sv
// Up-counter with synchronous clear and a programmable terminal value.
// The count saturates at i_last so it can never leave its range.
module ctrl_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != i_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_last);

endmodule

// File: rtl/mac_seq_controller.sv
// Load/multiply/sum sequencer: NUM_CH loads, MUL_LAT multiply cycles and one
// sum per iteration, repeated for a latched iteration count, with abort and done/ack.
module mac_seq_controller
    import mac_ctrl_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CH_W     = 1,
    parameter int MUL_LAT  = 1,
    parameter int ITER_W   = 4,
    parameter int AUTO_ACK = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] iter_num,
    input  logic              abort,
    input  logic              done_ack,
    output logic              input_en,
    output logic              load_in,
    output logic [CH_W-1:0]   ch_sel,
    output logic              sel_old_or_new,
    output logic              mul_en,
    output logic              sum_en,
    output logic              done,
    output logic              busy,
    output logic [ITER_W-1:0] iter_idx
);

    localparam int                MUL_W    = cnt_width(MUL_LAT);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [MUL_W-1:0]  MUL_LAST = MUL_W'(MUL_LAT - 1);

    state_e              r_state;
    ctrl_flags_t         r_flags;
    logic [ITER_W-1:0]   r_iter_total;

    logic                w_abort;
    logic                w_done_exit;
    logic [ITER_W-1:0]   w_iter_last;
    logic [CH_W-1:0]     w_ch_count;
    logic                w_ch_tc;
    logic [MUL_W-1:0]    w_mul_count;
    logic                w_mul_tc;
    logic [ITER_W-1:0]   w_iter_count;
    logic                w_iter_tc;

    // Abort only has meaning once a run is under way.
    assign w_abort     = abort && (r_state != ST_IDLE);
    assign w_done_exit = (r_state == ST_DONE) && ((AUTO_ACK != 0) || done_ack);
    assign w_iter_last = r_iter_total - 1'b1;

    ctrl_counter #(.W(CH_W)) u_ch_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .i_clr   (w_abort || (r_state != ST_LOAD) || w_ch_tc),
        .i_en    (r_state == ST_LOAD),
        .i_last  (CH_LAST),
        .o_count (w_ch_count),
        .o_tc    (w_ch_tc)
    );

    ctrl_counter #(.W(MUL_W)) u_mul_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .i_clr   (w_abort || (r_state != ST_MUL) || w_mul_tc),
        .i_en    (r_state == ST_MUL),
        .i_last  (MUL_LAST),
        .o_count (w_mul_count),
        .o_tc    (w_mul_tc)
    );

    // Cleared on the way back to IDLE so iter_idx reads 0 whenever the block is idle.
    ctrl_counter #(.W(ITER_W)) u_iter_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .i_clr   (w_abort || w_done_exit || (r_state == ST_IDLE)),
        .i_en    ((r_state == ST_SUM) && !w_iter_tc),
        .i_last  (w_iter_last),
        .o_count (w_iter_count),
        .o_tc    (w_iter_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_flags      <= state_flags(ST_IDLE);
            r_iter_total <= '0;
        end else if (w_abort) begin
            r_state <= ST_IDLE;
            r_flags <= state_flags(ST_IDLE);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_iter_total <= (iter_num == '0) ? ITER_W'(1) : iter_num;
                        r_state      <= ST_LOAD;
                        r_flags      <= state_flags(ST_LOAD);
                    end
                end
                ST_LOAD: begin
                    if (w_ch_tc) begin
                        r_state <= ST_MUL;
                        r_flags <= state_flags(ST_MUL);
                    end
                end
                ST_MUL: begin
                    if (w_mul_tc) begin
                        r_state <= ST_SUM;
                        r_flags <= state_flags(ST_SUM);
                    end
                end
                ST_SUM: begin
                    if (w_iter_tc) begin
                        r_state <= ST_DONE;
                        r_flags <= state_flags(ST_DONE);
                    end else begin
                        r_state <= ST_LOAD;
                        r_flags <= state_flags(ST_LOAD);
                    end
                end
                ST_DONE: begin
                    if (w_done_exit) begin
                        r_state <= ST_IDLE;
                        r_flags <= state_flags(ST_IDLE);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_flags <= state_flags(ST_IDLE);
                end
            endcase
        end
    end

    assign input_en       = r_flags.input_en;
    assign load_in        = r_flags.load_in;
    assign mul_en         = r_flags.mul_en;
    assign sum_en         = r_flags.sum_en;
    assign done           = r_flags.done;
    assign busy           = !r_flags.input_en;
    assign ch_sel         = w_ch_count;
    assign iter_idx       = w_iter_count;
    assign sel_old_or_new = r_flags.load_in && (w_iter_count == '0);

endmodule

// File: tb/tb_mac_seq_controller.sv
// Directed bench for mac_seq_controller: three instances (base, MUL_LAT=3,
// AUTO_ACK=1) share stimulus; each scenario checks the instance it targets.
module tb_mac_seq_controller;

    typedef enum int {P_IDLE, P_LOAD, P_MUL, P_SUM, P_DONE} phase_e;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] iter_num;
    logic       abort;
    logic       done_ack;

    logic       a_ie, a_ld, a_sel, a_mul, a_sum, a_dn, a_busy;
    logic [0:0] a_cs;
    logic [3:0] a_it;
    logic       b_ie, b_ld, b_sel, b_mul, b_sum, b_dn, b_busy;
    logic [0:0] b_cs;
    logic [3:0] b_it;
    logic       c_ie, c_ld, c_sel, c_mul, c_sum, c_dn, c_busy;
    logic [0:0] c_cs;
    logic [3:0] c_it;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_seq_controller #(.NUM_CH(2), .CH_W(1), .MUL_LAT(1), .ITER_W(4), .AUTO_ACK(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .iter_num(iter_num), .abort(abort),
        .done_ack(done_ack), .input_en(a_ie), .load_in(a_ld), .ch_sel(a_cs),
        .sel_old_or_new(a_sel), .mul_en(a_mul), .sum_en(a_sum), .done(a_dn),
        .busy(a_busy), .iter_idx(a_it)
    );

    mac_seq_controller #(.NUM_CH(2), .CH_W(1), .MUL_LAT(3), .ITER_W(4), .AUTO_ACK(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .iter_num(iter_num), .abort(abort),
        .done_ack(done_ack), .input_en(b_ie), .load_in(b_ld), .ch_sel(b_cs),
        .sel_old_or_new(b_sel), .mul_en(b_mul), .sum_en(b_sum), .done(b_dn),
        .busy(b_busy), .iter_idx(b_it)
    );

    mac_seq_controller #(.NUM_CH(2), .CH_W(1), .MUL_LAT(1), .ITER_W(4), .AUTO_ACK(1)) dut_c (
        .clk(clk), .rst(rst), .start(start), .iter_num(iter_num), .abort(abort),
        .done_ack(done_ack), .input_en(c_ie), .load_in(c_ld), .ch_sel(c_cs),
        .sel_old_or_new(c_sel), .mul_en(c_mul), .sum_en(c_sum), .done(c_dn),
        .busy(c_busy), .iter_idx(c_it)
    );

    function automatic logic [11:0] mk(input logic ie, ld, cs, sel, mul, sum, dn, bz,
                                       input logic [3:0] it);
        return {ie, ld, cs, sel, mul, sum, dn, bz, it};
    endfunction

    function automatic logic [11:0] obs(input int which);
        case (which)
            0:       return mk(a_ie, a_ld, a_cs[0], a_sel, a_mul, a_sum, a_dn, a_busy, a_it);
            1:       return mk(b_ie, b_ld, b_cs[0], b_sel, b_mul, b_sum, b_dn, b_busy, b_it);
            default: return mk(c_ie, c_ld, c_cs[0], c_sel, c_mul, c_sum, c_dn, c_busy, c_it);
        endcase
    endfunction

    function automatic logic [11:0] exp_vec(input phase_e p, input int ch, input int it);
        logic [3:0] it4;
        logic       ch1;
        it4 = it[3:0];
        ch1 = ch[0];
        return mk(p == P_IDLE, p == P_LOAD, ch1, (p == P_LOAD) && (it == 0),
                  p == P_MUL, p == P_SUM, p == P_DONE, p != P_IDLE, it4);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %03h expected %03h", tag, got, exp);
        end
    endtask

    task automatic expect_ph(input int which, input string tag, input phase_e p,
                             input int ch, input int it);
        check(tag, 32'(obs(which)), 32'(exp_vec(p, ch, it)));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    // Starts a run from IDLE and checks every cycle up to and including the first DONE cycle.
    task automatic run_to_done(input int which, input int n_req, input int lat, input string tag);
        int n;
        n        = (n_req == 0) ? 1 : n_req;
        start    = 1'b1;
        iter_num = n_req[3:0];
        for (int it = 0; it < n; it++) begin
            for (int c = 0; c < 2; c++) begin
                step();
                start    = 1'b0;
                iter_num = 4'hA;
                expect_ph(which, $sformatf("%s it%0d load%0d", tag, it, c), P_LOAD, c, it);
            end
            for (int m = 0; m < lat; m++) begin
                step();
                expect_ph(which, $sformatf("%s it%0d mul%0d", tag, it, m), P_MUL, 0, it);
            end
            step();
            expect_ph(which, $sformatf("%s it%0d sum", tag, it), P_SUM, 0, it);
        end
        step();
        expect_ph(which, $sformatf("%s done", tag), P_DONE, 0, n - 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        done_ack = 1'b0;
        iter_num = 4'd0;
        repeat (2) step();
        expect_ph(0, "in_reset a", P_IDLE, 0, 0);
        expect_ph(1, "in_reset b", P_IDLE, 0, 0);
        expect_ph(2, "in_reset c", P_IDLE, 0, 0);
        rst = 1'b1;
        step();
        expect_ph(0, "after_reset", P_IDLE, 0, 0);

        abort    = 1'b1;
        start    = 1'b1;
        iter_num = 4'd1;
        step();
        abort = 1'b0;
        start = 1'b0;
        expect_ph(0, "abort_in_idle", P_IDLE, 0, 0);

        run_to_done(0, 1, 1, "single");
        step();
        expect_ph(0, "single done_hold", P_DONE, 0, 0);
        done_ack = 1'b1;
        step();
        done_ack = 1'b0;
        expect_ph(0, "single after_ack", P_IDLE, 0, 0);

        run_to_done(0, 3, 1, "three");
        done_ack = 1'b1;
        start    = 1'b1;
        iter_num = 4'd2;
        step();
        done_ack = 1'b0;
        start    = 1'b0;
        expect_ph(0, "ack_with_start", P_IDLE, 0, 0);
        step();
        expect_ph(0, "start_not_taken", P_IDLE, 0, 0);

        do_reset();
        start    = 1'b1;
        iter_num = 4'd3;
        step();
        start = 1'b0;
        expect_ph(0, "abrt it0 load0", P_LOAD, 0, 0);
        step();
        expect_ph(0, "abrt it0 load1", P_LOAD, 1, 0);
        step();
        expect_ph(0, "abrt it0 mul", P_MUL, 0, 0);
        step();
        expect_ph(0, "abrt it0 sum", P_SUM, 0, 0);
        step();
        expect_ph(0, "abrt it1 load0", P_LOAD, 0, 1);
        step();
        expect_ph(0, "abrt it1 load1", P_LOAD, 1, 1);
        step();
        expect_ph(0, "abrt it1 mul", P_MUL, 0, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        expect_ph(0, "abrt idle", P_IDLE, 0, 0);
        step();
        expect_ph(0, "abrt stays_idle", P_IDLE, 0, 0);
        run_to_done(0, 2, 1, "post_abort");
        done_ack = 1'b1;
        step();
        done_ack = 1'b0;
        expect_ph(0, "post_abort idle", P_IDLE, 0, 0);

        do_reset();
        run_to_done(1, 0, 3, "zero_iter");
        done_ack = 1'b1;
        step();
        done_ack = 1'b0;
        expect_ph(1, "zero_iter idle", P_IDLE, 0, 0);

        do_reset();
        run_to_done(0, 15, 1, "max_iter");
        done_ack = 1'b1;
        step();
        done_ack = 1'b0;
        expect_ph(0, "max_iter idle", P_IDLE, 0, 0);

        do_reset();
        start    = 1'b1;
        iter_num = 4'd1;
        step();
        expect_ph(2, "auto load0", P_LOAD, 0, 0);
        step();
        expect_ph(2, "auto load1", P_LOAD, 1, 0);
        step();
        expect_ph(2, "auto mul", P_MUL, 0, 0);
        step();
        expect_ph(2, "auto sum", P_SUM, 0, 0);
        step();
        expect_ph(2, "auto done", P_DONE, 0, 0);
        step();
        expect_ph(2, "auto idle", P_IDLE, 0, 0);
        step();
        expect_ph(2, "auto restart", P_LOAD, 0, 0);
        start = 1'b0;

        do_reset();
        start    = 1'b1;
        iter_num = 4'd3;
        step();
        start = 1'b0;
        step();
        step();
        expect_ph(0, "pre_rst mul", P_MUL, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        expect_ph(0, "mid_rst a", P_IDLE, 0, 0);
        expect_ph(1, "mid_rst b", P_IDLE, 0, 0);
        expect_ph(2, "mid_rst c", P_IDLE, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        expect_ph(0, "post_rst idle", P_IDLE, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
